// File: rtl/vend_pkg.sv
// Shared encodings and constants for the vending controller: FSM states,
// timer commands, coin codes/values and the product price table.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_SEL = 2'b01,
    ST_PROD_RET = 2'b10,
    ST_CHG_RET  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    TMR_NONE           = 2'b00,
    TMR_WAIT_SELECT    = 2'b01,
    TMR_PRODUCT_RETURN = 2'b10,
    TMR_CHANGE_RETURN  = 2'b11
  } timer_cmd_e;

  localparam logic [1:0] COIN_CODE_INVALID = 2'b00;
  localparam logic [1:0] COIN_CODE_5       = 2'b01;
  localparam logic [1:0] COIN_CODE_10      = 2'b10;
  localparam logic [1:0] COIN_CODE_20      = 2'b11;

  localparam int unsigned COIN_VAL_5  = 5;
  localparam int unsigned COIN_VAL_10 = 10;
  localparam int unsigned COIN_VAL_20 = 20;

  localparam int unsigned PRICE_TABLE [4] = '{15, 20, 25, 40};

  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_CODE_5:  return COIN_VAL_5;
      COIN_CODE_10: return COIN_VAL_10;
      COIN_CODE_20: return COIN_VAL_20;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_price_lut.sv
// Combinational product-index to price lookup, sized to the caller's
// comparison width.
module vend_price_lut
  import vend_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [1:0]   i_select_id,
  output logic [W-1:0] o_price
);

  always_comb begin
    o_price = W'(PRICE_TABLE[i_select_id]);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: credit accumulation, product dispense,
// change return and timer commands. Every output is a register.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                select_valid,
  input  logic [1:0]          select_id,
  input  logic                cancel,
  input  logic                timeout_flag,
  output logic [1:0]          start_timer,
  output logic                dispense_valid,
  output logic [1:0]          dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic                err_funds,
  output logic [CREDIT_W-1:0] credit
);

  localparam int CW1 = CREDIT_W + 1;
  localparam logic [CW1-1:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  state_e              r_state, w_state_next;
  timer_cmd_e          r_timer, w_timer_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_next;
  logic                r_disp_valid, w_disp_valid_next;
  logic [1:0]          r_disp_id, w_disp_id_next;
  logic                r_chg_valid, w_chg_valid_next;
  logic [CREDIT_W-1:0] r_chg_amt, w_chg_amt_next;
  logic                r_coin_reject, w_coin_reject_next;
  logic                r_err_funds, w_err_funds_next;

  logic [CW1-1:0] w_price;
  logic [CW1-1:0] w_coin_val;
  logic [CW1-1:0] w_coin_sum;
  logic           w_coin_ok;
  logic           w_can_buy;
  logic           w_go_chg;

  vend_price_lut #(.W(CW1)) u_price_lut (
    .i_select_id (select_id),
    .o_price     (w_price)
  );

  // Sum is one bit wider so overflow past the credit range is detectable.
  assign w_coin_val = CW1'(coin_value(coin_code));
  assign w_coin_sum = {1'b0, r_credit} + w_coin_val;
  assign w_coin_ok  = coin_valid && (coin_code != COIN_CODE_INVALID) &&
                      (w_coin_sum <= CREDIT_MAX);
  assign w_can_buy  = select_valid && ({1'b0, r_credit} >= w_price);

  always_comb begin
    w_state_next       = r_state;
    w_credit_next      = r_credit;
    w_timer_next       = TMR_NONE;
    w_disp_valid_next  = 1'b0;
    w_disp_id_next     = 2'b00;
    w_chg_valid_next   = 1'b0;
    w_chg_amt_next     = '0;
    w_coin_reject_next = coin_valid;  // cleared only where a coin is accepted
    w_err_funds_next   = 1'b0;
    w_go_chg           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_coin_ok) begin
          w_credit_next      = w_coin_sum[CREDIT_W-1:0];
          w_state_next       = ST_WAIT_SEL;
          w_timer_next       = TMR_WAIT_SELECT;
          w_coin_reject_next = 1'b0;
        end
      end
      ST_WAIT_SEL: begin
        if (w_can_buy) begin
          w_credit_next     = r_credit - w_price[CREDIT_W-1:0];
          w_disp_valid_next = 1'b1;
          w_disp_id_next    = select_id;
          w_state_next      = ST_PROD_RET;
          w_timer_next      = TMR_PRODUCT_RETURN;
        end else begin
          // An unaffordable select only flags; lower-priority events still act.
          w_err_funds_next = select_valid;
          if (cancel) begin
            w_go_chg = 1'b1;
          end else if (w_coin_ok) begin
            w_credit_next      = w_coin_sum[CREDIT_W-1:0];
            w_timer_next       = TMR_WAIT_SELECT;
            w_coin_reject_next = 1'b0;
          end else if (timeout_flag) begin
            w_go_chg = 1'b1;
          end
        end
      end
      ST_PROD_RET: begin
        if (timeout_flag) begin
          if (r_credit != '0) w_go_chg = 1'b1;
          else                w_state_next = ST_IDLE;
        end
      end
      ST_CHG_RET: begin
        if (timeout_flag) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_go_chg) begin
      w_state_next     = ST_CHG_RET;
      w_timer_next     = TMR_CHANGE_RETURN;
      w_chg_valid_next = 1'b1;
      w_chg_amt_next   = r_credit;
      w_credit_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= TMR_NONE;
      r_credit      <= '0;
      r_disp_valid  <= 1'b0;
      r_disp_id     <= 2'b00;
      r_chg_valid   <= 1'b0;
      r_chg_amt     <= '0;
      r_coin_reject <= 1'b0;
      r_err_funds   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_credit      <= w_credit_next;
      r_disp_valid  <= w_disp_valid_next;
      r_disp_id     <= w_disp_id_next;
      r_chg_valid   <= w_chg_valid_next;
      r_chg_amt     <= w_chg_amt_next;
      r_coin_reject <= w_coin_reject_next;
      r_err_funds   <= w_err_funds_next;
    end
  end

  assign start_timer    = r_timer;
  assign dispense_valid = r_disp_valid;
  assign dispense_id    = r_disp_id;
  assign change_valid   = r_chg_valid;
  assign change_amount  = r_chg_amt;
  assign coin_reject    = r_coin_reject;
  assign err_funds      = r_err_funds;
  assign credit         = r_credit;

endmodule
